register_file_mp: RTL and testbench
===================================

// Module: register_file_mp
// PURPOSE
//  Parametrised multi-port register file for the pipelined core; successor to the single-write-port RF.
//  Provides 3 registered read ports (Rn, Rm, Rs shift operand), 2 write ports (result + base writeback)
//    and PC read-through on the PC index.
//  Contents are cleared by a one-register-per-cycle init sweep after reset; READY gates use.
//  Sits between decode (read addresses) and writeback (write ports).
// PARAMETERS
//  DATA_W   32  register width in bits
//  ADDR_W   4   address width; NUM_REGS = 2**ADDR_W (localparam)
//  PC_IDX   15  index whose reads return R15 input; writes to it are dropped
//  RST_VAL  0   value written to every register by the init sweep
// PORTS
//  clk    in   1       single clock; all state updates on posedge
//  rst    in   1       synchronous, active-high reset
//  RA1    in   ADDR_W  read address, port 1
//  RA2    in   ADDR_W  read address, port 2
//  RA3    in   ADDR_W  read address, port 3
//  WE3    in   1       write enable, port A
//  WA3    in   ADDR_W  write address, port A
//  WD3    in   DATA_W  write data, port A
//  WE4    in   1       write enable, port B
//  WA4    in   ADDR_W  write address, port B
//  WD4    in   DATA_W  write data, port B
//  R15    in   DATA_W  current PC value (PC+8 from fetch)
//  RD1    out  DATA_W  read data, port 1 (registered)
//  RD2    out  DATA_W  read data, port 2 (registered)
//  RD3    out  DATA_W  read data, port 3 (registered)
//  READY  out  1       high once init sweep complete
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state<=INIT, sweep cnt<=0, READY<=0, RD1..RD3<=0.
//    Register contents are not touched by rst itself.
//  - FSM INIT: each cycle reg[cnt]<=RST_VAL, cnt<=cnt+1.
//    On cnt==NUM_REGS-1 -> RUN, READY<=1 next edge; sweep takes exactly NUM_REGS cycles after rst drops.
//  - INIT: WE3/WE4 ignored; RD1..RD3 register 0 every cycle.
//  - rst asserted mid-sweep or in RUN restarts the sweep from cnt=0.
//  - RUN writes: at posedge, reg[WA3]<=WD3 if WE3; reg[WA4]<=WD4 if WE4.
//  - Same-address collision with WE3=WE4=1: port A (WD3) wins; port B write is dropped.
//  - Writes to PC_IDX are dropped; the PC storage lives outside this block.
//  - RUN reads: RDn <= value(RAn) at posedge; 1-cycle latency, address sampled at same edge.
//  - RAn==PC_IDX: RDn <= R15 as sampled at that edge; no bypass applies.
//  - All three read ports may address the same register; each returns an identical value.
//  - No arithmetic; widths fixed at DATA_W, no truncation or extension.
// CONFIGURATION
//  RF_BYPASS_EN defined: write-first forwarding.
//    If RAn matches an enabled write address in the same cycle, RDn gets that write data
//    (WD3 if both ports match).
//  RF_BYPASS_EN undefined: read-first; RDn gets the pre-write contents and the new value is visible a cycle later.
//  Neither mode affects PC_IDX reads or INIT behaviour.
// TESTING
//  1. rst 1 cycle, then idle -> READY=0 for 16 cycles, 1 on 17th edge; all regs read 0 afterwards.
//  2. RUN: WE3=1 WA3=2 WD3=0xDEADBEEF, next cycle RA1=2 -> RD1=0xDEADBEEF one edge later.
//  3. WE3=WE4=1, WA3=WA4=5, WD3=0x11, WD4=0x22 -> reg5 reads 0x11.
//  4. RA2=15, R15=0x00000108; WE3=1 WA3=15 WD3=0x55 -> RD2=0x108; later reads still track R15.
//  5. Same cycle WE4=1 WA4=7 WD4=0xA5A5A5A5, RA3=7 (reg7 was 0x1):
//     bypass on -> RD3=0xA5A5A5A5; off -> RD3=0x1, then 0xA5A5A5A5 next cycle.
//  6. Write reg3=0x77, assert rst at sweep cnt=8 -> READY stays 0, sweep restarts, reg3 reads RST_VAL after READY.

Source files
------------

// File: rtl/register_file_mp.sv
// Multi-port register file: 3 registered reads, 2 writes, PC read-through, init sweep.
// Optional RF_BYPASS_EN selects write-first forwarding; undefined gives read-first.
module register_file_mp #(
    parameter int                 DATA_W  = 32,
    parameter int                 ADDR_W  = 4,
    parameter int                 PC_IDX  = 15,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    input  logic [ADDR_W-1:0] RA3,
    input  logic              WE3,
    input  logic [ADDR_W-1:0] WA3,
    input  logic [DATA_W-1:0] WD3,
    input  logic              WE4,
    input  logic [ADDR_W-1:0] WA4,
    input  logic [DATA_W-1:0] WD4,
    input  logic [DATA_W-1:0] R15,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic [DATA_W-1:0] RD3,
    output logic              READY
);

    localparam int                NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC_A     = ADDR_W'(PC_IDX);
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   rd_q [3];
    logic [DATA_W-1:0]   rd_d [3];
    logic [ADDR_W-1:0]   ra [3];
    logic                we3_eff;
    logic                we4_eff;

    assign ra[0] = RA1;
    assign ra[1] = RA2;
    assign ra[2] = RA3;

    // Port A always wins a same-address collision, so port B drops out.
    assign we3_eff = WE3 && (state_q == ST_RUN) && (WA3 != PC_A);
    assign we4_eff = WE4 && (state_q == ST_RUN) && (WA4 != PC_A)
                     && !(WE3 && (WA3 == WA4));

    // Sweep sequencing: INIT clears one register per cycle, then RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        unique case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // FSM state, sweep counter and READY flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Storage: sweep clear in INIT, port writes in RUN; rst leaves contents alone.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                regs_q[cnt_q] <= RST_VAL;
            end else begin
                if (we4_eff) regs_q[WA4] <= WD4;
                if (we3_eff) regs_q[WA3] <= WD3;
            end
        end
    end

    // Next read data per port; PC index always reflects the live R15 input.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_d[p] = regs_q[ra[p]];
`ifdef RF_BYPASS_EN
            if (we4_eff && (WA4 == ra[p])) rd_d[p] = WD4;
            if (we3_eff && (WA3 == ra[p])) rd_d[p] = WD3;
`endif
            if (ra[p] == PC_A) rd_d[p] = R15;
            if (state_q != ST_RUN) rd_d[p] = '0;
        end
    end

    // Registered read outputs, one cycle of latency.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 3; p++) begin
            if (rst) rd_q[p] <= '0;
            else     rd_q[p] <= rd_d[p];
        end
    end

    assign RD1   = rd_q[0];
    assign RD2   = rd_q[1];
    assign RD3   = rd_q[2];
    assign READY = ready_q;

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed cases then random traffic.
// Expected values come from an array model driven by cycles-since-reset.
module tb_register_file_mp;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 16;
    localparam int PC = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] RA1 = '0, RA2 = '0, RA3 = '0;
    logic          WE3 = 1'b0, WE4 = 1'b0;
    logic [AW-1:0] WA3 = '0, WA4 = '0;
    logic [DW-1:0] WD3 = '0, WD4 = '0, R15 = '0;
    logic [DW-1:0] RD1, RD2, RD3;
    logic          READY;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DW-1:0] m_regs [NR];
    int            since_rst = 0;
    logic [DW-1:0] e_rd [3];
    logic          e_ready = 1'b0;

    register_file_mp dut (
        .clk   (clk),
        .rst   (rst),
        .RA1   (RA1),
        .RA2   (RA2),
        .RA3   (RA3),
        .WE3   (WE3),
        .WA3   (WA3),
        .WD3   (WD3),
        .WE4   (WE4),
        .WA4   (WA4),
        .WD4   (WD4),
        .R15   (R15),
        .RD1   (RD1),
        .RD2   (RD2),
        .RD3   (RD3),
        .READY (READY)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Predict the outcome of the coming edge from the current inputs.
    task automatic model_edge();
        logic [AW-1:0] ra [3];
        ra[0] = RA1;
        ra[1] = RA2;
        ra[2] = RA3;
        if (rst) begin
            since_rst = 0;
            e_ready   = 1'b0;
            for (int p = 0; p < 3; p++) e_rd[p] = '0;
        end else if (since_rst < NR) begin
            m_regs[since_rst] = '0;
            since_rst++;
            e_ready = (since_rst == NR);
            for (int p = 0; p < 3; p++) e_rd[p] = '0;
        end else begin
            e_ready = 1'b1;
            for (int p = 0; p < 3; p++) begin
                e_rd[p] = m_regs[ra[p]];
`ifdef RF_BYPASS_EN
                if (WE4 && WA4 == ra[p]) e_rd[p] = WD4;
                if (WE3 && WA3 == ra[p]) e_rd[p] = WD3;
`endif
                if (int'(ra[p]) == PC) e_rd[p] = R15;
            end
            if (WE4 && int'(WA4) != PC && !(WE3 && WA3 == WA4))
                m_regs[WA4] = WD4;
            if (WE3 && int'(WA3) != PC)
                m_regs[WA3] = WD3;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("rd1", RD1, e_rd[0]);
        check("rd2", RD2, e_rd[1]);
        check("rd3", RD3, e_rd[2]);
        check("ready", {31'b0, READY}, {31'b0, e_ready});
    endtask

    task automatic idle();
        WE3 = 1'b0;
        WE4 = 1'b0;
    endtask

    initial begin
        // 1: reset, sweep timing, all registers cleared
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (15) tick();
        check("t1_ready_lo", {31'b0, READY}, 32'd0);
        tick();
        check("t1_ready_hi", {31'b0, READY}, 32'd1);
        for (int i = 0; i < NR; i++) begin
            RA1 = AW'(i);
            RA2 = AW'(i);
            RA3 = AW'(NR - 1 - i);
            R15 = $urandom;
            tick();
        end

        // 2: write then read back
        WE3 = 1'b1; WA3 = 4'd2; WD3 = 32'hDEADBEEF;
        tick();
        idle();
        RA1 = 4'd2;
        tick();
        check("t2_rd1", RD1, 32'hDEADBEEF);

        // 3: collision, port A wins
        WE3 = 1'b1; WA3 = 4'd5; WD3 = 32'h11;
        WE4 = 1'b1; WA4 = 4'd5; WD4 = 32'h22;
        tick();
        idle();
        RA1 = 4'd5;
        tick();
        check("t3_rd1", RD1, 32'h11);

        // 4: PC read-through, PC write dropped
        RA2 = 4'd15; R15 = 32'h108;
        WE3 = 1'b1; WA3 = 4'd15; WD3 = 32'h55;
        tick();
        check("t4_rd2", RD2, 32'h108);
        idle();
        R15 = 32'h10C;
        tick();
        check("t4_rd2_track", RD2, 32'h10C);

        // 5: same-cycle write/read of reg7
        WE3 = 1'b1; WA3 = 4'd7; WD3 = 32'h1;
        tick();
        idle();
        WE4 = 1'b1; WA4 = 4'd7; WD4 = 32'hA5A5A5A5; RA3 = 4'd7;
        tick();
`ifdef RF_BYPASS_EN
        check("t5_rd3_now", RD3, 32'hA5A5A5A5);
`else
        check("t5_rd3_now", RD3, 32'h1);
`endif
        idle();
        tick();
        check("t5_rd3_next", RD3, 32'hA5A5A5A5);

        // 6: reset mid-sweep restarts it
        WE3 = 1'b1; WA3 = 4'd3; WD3 = 32'h77;
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (15) tick();
        check("t6_ready_lo", {31'b0, READY}, 32'd0);
        tick();
        check("t6_ready_hi", {31'b0, READY}, 32'd1);
        RA1 = 4'd3;
        tick();
        check("t6_rd1", RD1, 32'h0);

        // random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            RA1 = AW'($urandom);
            RA2 = AW'($urandom);
            RA3 = AW'($urandom);
            WE3 = 1'($urandom);
            WE4 = 1'($urandom);
            WA3 = AW'($urandom);
            WA4 = AW'($urandom);
            WD3 = $urandom;
            WD4 = $urandom;
            R15 = $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
